// File: rtl/mem_io_responder_pkg.sv
// mem_io_responder_pkg: shared address map and widths for the memory/IO responder
package mem_io_responder_pkg;
  localparam int BYTE_W = 8;
  localparam int RAM_ADDR_BITS_DEF = 17;
  localparam int REGION_HI = 17;
  localparam int REGION_LO = 16;
  localparam logic [1:0] REGION_IO = 2'b11;
  localparam logic [17:0] IO_BASE = 18'h30000;
  localparam logic [17:0] CNT_ADDR = 18'h30004;
endpackage

// File: rtl/resp_tx_fifo.sv
// resp_tx_fifo: circular first-word-fall-through byte FIFO with drop-on-full reporting
module resp_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic [AW:0]   count_o,
  output logic [AW:0]   count_next_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          drop_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wp_q, rp_q, wp_d, rp_d;
  logic do_push, do_pop;
  assign count_o = wp_q - rp_q;
  assign full_o = count_o == (AW+1)'(DEPTH);
  assign empty_o = wp_q == rp_q;
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o = push_i && full_o && !do_pop;
  assign wp_d = wp_q + (AW+1)'(do_push);
  assign rp_d = rp_q + (AW+1)'(do_pop);
  assign count_next_o = wp_d - rp_d;
  assign data_o = empty_o ? '0 : mem_q[rp_q[AW-1:0]];
  // pointer registers; the extra MSB distinguishes full from empty
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
  // storage is not reset; stale entries are unreachable once the pointers clear
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= push_data_i;
  end
endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM plus memory-mapped UART TX/RX, cycle counter and stop latch
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF,
  parameter int TX_DEPTH = 8,
  parameter int FULL_MARGIN = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [31:0]       mem_a,
  input  logic [BYTE_W-1:0] mem_dout,
  input  logic              mem_wr,
  output logic [BYTE_W-1:0] mem_din,
  output logic              io_buffer_full,
  output logic              tx_valid,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              program_stop,
  output logic              tx_overflow
);
  localparam int CW = $clog2(TX_DEPTH) + 1;
  logic [BYTE_W-1:0] ram [2**RAM_ADDR_BITS];
  logic [17:0] a;
  logic unused_hi;
  logic sel_ram, is_io, is_rx, is_cnt, is_stop, rd_rx, rd_cnt0, rx_load;
  logic tx_push, tx_drop, tx_empty, near_full;
  logic [BYTE_W-1:0] rd_data, tx_push_data;
  logic [CW-1:0] tx_count_next, unused_count;
  logic unused_full;
  logic rx_full_q, ibf_q, stop_q, ovf_q;
  logic [BYTE_W-1:0] rx_byte_q, mem_din_q;
  logic [31:0] cnt_q, snap_q;
  assign a = mem_a[17:0];
  assign unused_hi = ^mem_a[31:18];
  assign sel_ram = !a[REGION_HI];
  assign is_io = a[REGION_HI:REGION_LO] == REGION_IO;
  assign is_rx = is_io && a[15:0] == IO_BASE[15:0];
  assign is_cnt = is_io && a[15:2] == CNT_ADDR[15:2];
  assign is_stop = is_io && a[15:0] == CNT_ADDR[15:0];
  assign rd_rx = !mem_wr && is_rx;
  assign rd_cnt0 = !mem_wr && is_cnt && a[1:0] == 2'd0;
  assign rx_load = rx_valid && !rx_full_q;
  assign tx_push = mem_wr && ((is_rx && |mem_dout) || is_stop);
  assign tx_push_data = is_stop ? '0 : mem_dout;
  assign near_full = int'(tx_count_next) >= TX_DEPTH - FULL_MARGIN;
  // read mux: byte 0 of the counter is live, upper bytes come from the snapshot
  always_comb begin
    rd_data = sel_ram ? ram[a[RAM_ADDR_BITS-1:0]] :
              is_rx   ? (rx_full_q ? rx_byte_q : '0) :
              is_cnt  ? (a[1:0] == 2'd0 ? cnt_q[7:0] : snap_q[{a[1:0], 3'b000} +: 8]) :
              '0;
  end
  resp_tx_fifo #(.DEPTH(TX_DEPTH), .W(BYTE_W)) u_tx (
    .clk_i(clk_in),
    .rst_ni(rst_in),
    .push_i(tx_push),
    .push_data_i(tx_push_data),
    .pop_i(tx_ready),
    .data_o(tx_data),
    .count_o(unused_count),
    .count_next_o(tx_count_next),
    .full_o(unused_full),
    .empty_o(tx_empty),
    .drop_o(tx_drop)
  );
  // RAM survives reset; a write presented while reset is low is discarded
  always_ff @(posedge clk_in) begin
    if (rst_in && mem_wr && sel_ram) ram[a[RAM_ADDR_BITS-1:0]] <= mem_dout;
  end
  // read data, RX holding register, counter and sticky status flags
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_din_q <= '0;
      rx_full_q <= 1'b0;
      rx_byte_q <= '0;
      cnt_q <= '0;
      snap_q <= '0;
      ibf_q <= 1'b0;
      stop_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
      if (rd_cnt0) snap_q <= cnt_q;
      if (!mem_wr) mem_din_q <= rd_data;
      rx_full_q <= rx_load || (rx_full_q && !rd_rx);
      if (rx_load) rx_byte_q <= rx_data;
      ibf_q <= near_full;
      stop_q <= stop_q || (mem_wr && is_stop);
      ovf_q <= ovf_q || tx_drop;
    end
  end
  assign mem_din = mem_din_q;
  assign io_buffer_full = ibf_q;
  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full_q;
  assign program_stop = stop_q;
  assign tx_overflow = ovf_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: scoreboard bench with a queue-based reference model
module tb_mem_io_responder;
  logic clk_in = 0, rst_in = 1, mem_wr = 0, tx_ready = 0, rx_valid = 0;
  logic [31:0] mem_a = 32'h20000;
  logic [7:0] mem_dout = 0, rx_data = 0, mem_din, tx_data;
  logic io_buffer_full, tx_valid, rx_ready, program_stop, tx_overflow;
  int tests = 0, fails = 0;
  logic [7:0] ram_m [int];
  int wr_addrs[$];
  logic [7:0] txm[$], tx_exp[$], exp_q[$];
  bit rxf, ovf, stop, ibf;
  logic [7:0] rxb;
  logic [31:0] cnt, snap;
  bit mon_rd;
  logic [7:0] mon_got;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .mem_din(mem_din), .io_buffer_full(io_buffer_full), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .program_stop(program_stop), .tx_overflow(tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // reference: one bus request applied at a clock edge, in terms of the address map
  task automatic model_step();
    logic [17:0] a;
    logic [7:0] v, pd;
    bit pop, push, load;
    a = mem_a[17:0];
    pop = tx_ready && txm.size() > 0;
    load = rx_valid && !rxf;
    push = 0;
    pd = 0;
    if (!mem_wr) begin
      v = 0;
      if (a < 18'h20000) v = ram_m.exists(int'(a)) ? ram_m[int'(a)] : 8'h00;
      else if (a == 18'h30000) begin
        v = rxf ? rxb : 8'h00;
        rxf = 0;
      end else if (a == 18'h30004) begin
        v = cnt[7:0];
        snap = cnt;
      end else if (a >= 18'h30005 && a <= 18'h30007) v = snap[8*int'(a[1:0]) +: 8];
      exp_q.push_back(v);
    end else begin
      if (a < 18'h20000) ram_m[int'(a)] = mem_dout;
      else if (a == 18'h30000 && mem_dout != 0) begin push = 1; pd = mem_dout; end
      else if (a == 18'h30004) begin push = 1; pd = 0; stop = 1; end
    end
    if (load) begin rxf = 1; rxb = rx_data; end
    if (pop) tx_exp.push_back(txm.pop_front());
    if (push) begin
      if (txm.size() < 8) txm.push_back(pd);
      else ovf = 1;
    end
    ibf = (8 - txm.size()) <= 2;
    cnt++;
  endtask

  task automatic check_flags();
    chk("tx_valid", tx_valid, txm.size() > 0);
    if (txm.size() > 0) chk("tx_data_head", tx_data, txm[0]);
    chk("io_buffer_full", io_buffer_full, ibf);
    chk("tx_overflow", tx_overflow, ovf);
    chk("program_stop", program_stop, stop);
    chk("rx_ready", rx_ready, !rxf);
  endtask

  task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] d);
    mem_a = a;
    mem_wr = wr;
    mem_dout = d;
    @(posedge clk_in);
    if (rst_in) model_step();
    #1;
    check_flags();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(32'h20000, 0, 0);
  endtask

  // assert reset between edges, check the immediate effect, release after two edges
  task automatic do_reset();
    rst_in = 0;
    mem_wr = 0;
    mem_a = 32'h20000;
    #1;
    txm.delete(); tx_exp.delete(); exp_q.delete();
    rxf = 0; ovf = 0; stop = 0; ibf = 0; cnt = 0; snap = 0;
    chk("rst_mem_din", mem_din, 0);
    chk("rst_tx_data", tx_data, 0);
    check_flags();
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1;
  endtask

  task automatic rand_cyc();
    logic [31:0] hi, a;
    int r;
    hi = $urandom & 32'hFFFC0000;
    tx_ready = $urandom_range(0, 1);
    rx_valid = $urandom_range(0, 3) == 0;
    rx_data = 8'($urandom);
    r = $urandom_range(0, 9);
    if (r <= 1) begin
      a = $urandom_range(0, 1) ? $urandom_range(0, 63) : 32'h1FFC0 + $urandom_range(0, 63);
      wr_addrs.push_back(int'(a));
      cyc(hi | a, 1, 8'($urandom));
    end else if (r <= 3 && wr_addrs.size() > 0)
      cyc(hi | 32'(wr_addrs[$urandom_range(0, wr_addrs.size() - 1)]), 0, 0);
    else if (r == 4) cyc(hi | (32'h20000 + $urandom_range(0, 16'hFFFF)), $urandom_range(0, 1), 8'($urandom));
    else if (r == 5) cyc(hi | 32'h30000, 0, 0);
    else if (r == 6) cyc(hi | 32'h30000, 1, $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom));
    else if (r == 7) cyc(hi | (32'h30004 + $urandom_range(0, 3)), 0, 0);
    else if (r == 8) cyc(hi | (32'h30008 + $urandom_range(0, 255)), $urandom_range(0, 1), 8'($urandom));
    else cyc(hi | 32'h30004, $urandom_range(0, 7) == 0, 8'($urandom));
  endtask

  // read-data monitor: a read seen at an edge is checked on the following falling edge
  initial forever begin
    @(posedge clk_in);
    mon_rd = rst_in && !mem_wr;
    @(negedge clk_in);
    if (mon_rd && rst_in) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL mem_din unexpected read data got=%0h", mem_din);
      end else chk("mem_din", mem_din, exp_q.pop_front());
    end
  end

  // TX monitor: byte presented at a handshake is matched against the model's emitted order
  initial forever begin
    @(negedge clk_in);
    if (rst_in && tx_valid && tx_ready) begin
      mon_got = tx_data;
      @(posedge clk_in);
      #1;
      if (tx_exp.size() == 0) begin
        tests++; fails++;
        $display("FAIL tx_emit unexpected byte got=%0h", mon_got);
      end else chk("tx_emit", mon_got, tx_exp.pop_front());
    end
  end

  initial begin
    #2;
    do_reset();
    cyc(32'h10, 1, 8'hA5);
    cyc(32'h10, 0, 0);
    cyc(32'h20010, 0, 0);
    cyc(32'h20010, 1, 8'h77);
    cyc(32'h20010, 0, 0);
    tx_ready = 0;
    cyc(32'h30000, 1, 8'h48);
    cyc(32'h30000, 1, 8'h69);
    cyc(32'h30000, 1, 8'h00);
    tx_ready = 1;
    idle(4);
    tx_ready = 0;
    for (int i = 1; i <= 9; i++) cyc(32'h30000, 1, 8'(i));
    cyc(32'h30000, 1, 8'hEE);
    tx_ready = 1;
    cyc(32'h30000, 1, 8'h55);
    idle(12);
    rx_valid = 1;
    rx_data = 8'h37;
    idle(1);
    rx_data = 8'h99;
    idle(1);
    rx_valid = 0;
    cyc(32'h30000, 0, 0);
    cyc(32'h30000, 0, 0);
    rx_valid = 1;
    rx_data = 8'h5C;
    cyc(32'h30000, 0, 0);
    rx_valid = 0;
    cyc(32'h30000, 0, 0);
    cyc(32'h10, 1, 8'h00);
    do_reset();
    tx_ready = 0;
    idle(300);
    for (int i = 4; i < 8; i++) cyc(32'h30000 + 32'(i), 0, 0);
    cyc(32'h30004, 1, 8'hFF);
    cyc(32'h30005, 0, 0);
    tx_ready = 1;
    idle(3);
    for (int i = 0; i < 3000; i++) rand_cyc();
    tx_ready = 0;
    rx_valid = 0;
    cyc(32'h30000, 1, 8'h11);
    cyc(32'h30000, 1, 8'h22);
    cyc(32'h30000, 1, 8'h33);
    cyc(32'h1ABCD, 1, 8'h3C);
    #2;
    do_reset();
    cyc(32'h30004, 0, 0);
    cyc(32'h1ABCD, 0, 0);
    cyc(32'h10, 0, 0);
    tx_ready = 1;
    idle(12);
    @(negedge clk_in);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("tx_exp_drained", tx_exp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
